cnu_msg_gen: RTL and testbench

Check-node message generator for the min-sum LDPC decoder. It takes the compressed check-node state (min, min2, min_idx) produced by the CNU compare tree, plus the per-edge input signs, and expands it back into D per-edge check-to-variable messages. Messages leave one edge per cycle on a valid/ready stream toward the VNU side. A one-deep pending buffer lets the next check node load while the current one is still emitting, so consecutive check nodes stream without a gap.

---
 rtl/cnu_msg_gen.sv | 100 ++++++++++
 tb/tb_cnu_msg_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cnu_msg_gen.sv
// Expands compressed min-sum check-node state (min, min2, min_idx, signs) into
// D per-edge check-to-variable messages, one edge per cycle, with a one-deep load buffer.
module cnu_msg_gen #(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int D      = 5,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   msg,
  output logic [idx_w-1:0]  msg_idx,
  output logic              last
);

  localparam int kw = (D > 1) ? $clog2(D) : 1;
  localparam logic [data_w-1:0] off = data_w'(OFFSET);

  typedef struct packed {
    logic [data_w-1:0] min;
    logic [data_w-1:0] min2;
    logic [idx_w-1:0]  idx;
    logic [D-1:0]      sign;
    logic              par;
  } cn_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t  state, state_nx;
  cn_t     act, pend, in_cn;
  logic    pend_full;
  logic [kw-1:0] k;
  logic    fire, fin, load, load_act;
  logic [data_w-1:0] mag;

  assign in_cn    = '{min: min, min2: min2, idx: min_idx, sign: sign_in, par: ^sign_in};
  assign in_ready = !pend_full;
  assign load     = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign fin      = fire && last;
  // A load bypasses pending only when active is free now or is retiring with nothing queued.
  assign load_act = load && ((state == IDLE) || (fin && !pend_full));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (load) state_nx = EMIT;
      EMIT: if (fin && !pend_full && !load_act) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      k         <= '0;
    end else begin
      if (fin && pend_full) begin
        act       <= pend;
        k         <= '0;
        pend_full <= 1'b0;
      end else if (load_act) begin
        act <= in_cn;
        k   <= '0;
      end else if (fire) begin
        k <= k + 1'b1;
      end
      if (load && !load_act) begin
        pend      <= in_cn;
        pend_full <= 1'b1;
      end
    end
  end

  // Edge matching min_idx gets min2; an out-of-range min_idx matches no edge.
  assign mag = (idx_w'(k) == act.idx) ? act.min2 : act.min;

  always_comb begin
    out_valid = (state == EMIT);
    msg       = {act.par ^ act.sign[k], (mag > off) ? mag - off : '0};
    msg_idx   = idx_w'(k);
    last      = (k == kw'(D - 1));
  end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Randomized and directed bench for cnu_msg_gen against a queue-based model of
// loaded check nodes (front = emitting, second = pending).
module tb_cnu_msg_gen;
  localparam int DW = 8, IW = 8, D = 5, OFFSET = 1;

  logic          clk = 1'b0, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, last;
  logic [DW-1:0] min, min2;
  logic [IW-1:0] min_idx, msg_idx;
  logic [D-1:0]  sign_in;
  logic [DW:0]   msg;

  cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(D), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .min(min), .min2(min2), .min_idx(min_idx), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .msg(msg),
    .msg_idx(msg_idx), .last(last)
  );

  always #5 clk = ~clk;

  typedef struct {int mn; int mn2; int idx; logic [D-1:0] sg;} node_t;
  node_t q[$];
  int mk;
  int total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_msg();
    node_t n = q[0];
    int mag = (mk == n.idx) ? n.mn2 : n.mn;
    int om  = (mag > OFFSET) ? mag - OFFSET : 0;
    int s   = (^n.sg) ^ n.sg[mk];
    return 32'(s * (1 << DW) + om);
  endfunction

  task automatic step(input bit iv, input int mn, input int mn2, input int idx,
                      input logic [D-1:0] sg, input bit ordy);
    bit ld, fr;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("msg", 32'(msg), exp_msg());
      chk("msg_idx", 32'(msg_idx), 32'(mk));
      chk("last", 32'(last), 32'(mk == D - 1));
    end
    in_valid = iv; min = DW'(mn); min2 = DW'(mn2); min_idx = IW'(idx);
    sign_in = sg; out_ready = ordy;
    ld = iv && (q.size() < 2);
    fr = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fr) begin
      mk++;
      if (mk == D) begin
        void'(q.pop_front());
        mk = 0;
      end
    end
    if (ld) q.push_back('{mn, mn2, idx, sg});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; out_ready = 0; min = 0; min2 = 0; min_idx = 0; sign_in = 0;
    mk = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_msg", 32'(msg), 0);
    chk("rst_msg_idx", 32'(msg_idx), 0);
    chk("rst_last", 32'(last), 0);
    @(negedge clk) rst_n = 1'b1;

    // basic expansion
    step(1, 3, 7, 2, 5'b00101, 1);
    idle(7);
    // backpressure hold on edge 1
    step(1, 3, 7, 2, 5'b00101, 1);
    step(0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, 0);
    idle(6);
    // A, B during A1, then C offered continuously until taken
    step(1, 10, 20, 1, 5'b10010, 1);
    step(0, 0, 0, 0, '0, 1);
    step(1, 5, 6, 4, 5'b01100, 1);
    for (int i = 0; i < 12; i++) begin
      bit acc = (q.size() < 2);
      step(1, 2, 9, 0, 5'b00001, 1);
      if (acc) break;
    end
    idle(14);
    // saturation at zero
    step(1, 0, 1, 0, 5'b00000, 1);
    idle(7);
    // min_idx out of range
    step(1, 4, 9, 7, 5'b11111, 1);
    idle(7);

    // async reset mid-emission with pending node
    step(1, 8, 12, 3, 5'b00110, 1);
    step(1, 1, 2, 0, 5'b11000, 1);
    step(0, 0, 0, 0, '0, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_msg", 32'(msg), 0);
    chk("arst_msg_idx", 32'(msg_idx), 0);
    chk("arst_last", 32'(last), 0);
    q.delete();
    mk = 0;
    @(negedge clk) rst_n = 1'b1;
    idle(8);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int mn  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255);
      int mn2 = $urandom_range(mn, 255);
      step($urandom_range(0, 1), mn, mn2, $urandom_range(0, 9),
           D'($urandom), $urandom_range(0, 9) < 7);
    end
    idle(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
